data_memory_responder: RTL
==========================

Name: data_memory_responder

Overview:
Word-addressed data memory acting as the responder on a valid/ready request/response interface. It replaces the zero-latency combinational data memory when the core moves to a handshaked load/store path. It accepts one read or write request at a time, inserts a fixed number of wait states, then holds a response until the initiator takes it. This lets the processor-side load/store logic be verified against realistic memory latency and backpressure.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words; power of two, at least 2.
WAIT_CYCLES, 2, wait states between request acceptance and response; 0 to 15.

Ports:
clock  input  1  single clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
req_valid  input  1  initiator presents a request.
req_ready  output  1  responder can accept a request.
req_write  input  1  1 means store, 0 means load.
req_addr  input  32  byte address.
req_wdata  input  32  store data.
resp_valid  output  1  response available.
resp_ready  input  1  initiator accepts the response.
resp_rdata  output  32  load data, or the written data on a store acknowledge.

Behaviour:
- Reset
  - Sampled at the rising edge only; overrides all other inputs.
  - State goes to IDLE; req_ready=1 the cycle after reset; resp_valid=0; resp_rdata=0.
  - Wait counter cleared; all memory words zeroed.
- Index
  - idx = req_addr[2 +: log2(DEPTH_WORDS)].
  - Upper bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
  - Without the optional feature, req_addr[1:0] is ignored.
- States: IDLE, WAIT, RESP.
  - IDLE: req_ready=1, resp_valid=0.
  - On req_valid&&req_ready at edge N, capture write, idx and wdata.
  - If WAIT_CYCLES==0, go to RESP; otherwise go to WAIT with counter=WAIT_CYCLES-1.
  - WAIT: req_ready=0. Decrement the counter each edge; go to RESP on the edge where counter==0.
  - The memory access happens on the edge that enters RESP.
    - Store: mem[idx]<=wdata, resp_rdata<=wdata.
    - Load: resp_rdata<=mem[idx].
  - RESP: resp_valid=1, req_ready=0; resp_rdata is held stable while resp_ready=0, with no limit on stall length.
  - On resp_valid&&resp_ready, go to IDLE; resp_valid=0 and req_ready=1 on the next cycle.
- Latency
  - resp_valid rises at cycle N+1+WAIT_CYCLES.
  - Minimum request-to-request spacing is WAIT_CYCLES+2 cycles.
  - No request is accepted in the same cycle a response completes.
- In WAIT and RESP, req_* inputs are don't-care; a changing req_addr does not affect the captured request.
- Reset in WAIT aborts the request: the store is not committed and no response is produced.
- Reset in RESP drops the pending response; a store that already committed is then zeroed by the reset clear.
- Load after store to the same idx returns the new data, since the store commits before RESP.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - Adds output port resp_err (1 bit), reset to 0 and valid only while resp_valid=1.
  - A request with req_addr[1:0]!=0 produces a response with resp_err=1 and resp_rdata=0, at the same latency.
  - A misaligned store does not write memory.
  - Aligned requests return resp_err=0.
- Not defined: no resp_err port; the low two address bits are ignored.

Test Plan:
1. Reset, then store 0xDEADBEEF to 0x10 with WAIT_CYCLES=2 -> req_ready low 3 cycles; resp_valid at N+3 with resp_rdata=0xDEADBEEF. A following load from 0x10 returns 0xDEADBEEF at N'+3.
2. WAIT_CYCLES=0: load from 0x04 after reset -> resp_valid at N+1 with resp_rdata=0x00000000. Back-to-back requests are accepted every 2 cycles.
3. Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid stays 1, resp_rdata is stable, req_ready=0. IDLE follows the cycle after resp_ready=1.
4. Wrap: DEPTH_WORDS=256; store 0x12345678 to 0x400, then load from 0x000 -> 0x12345678.
5. Reset mid-operation: assert reset during WAIT of a store 0xA5A5A5A5 to 0x20 -> no resp_valid. A later load from 0x20 returns 0.
6. With MISALIGN_TRAP_EN: store to 0x22 -> resp_err=1, resp_rdata=0. A subsequent load from 0x20 returns the prior contents; an aligned request returns resp_err=0.

Source files
------------

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - word-addressed data memory behind a valid/ready request/response handshake
// Optional MISALIGN_TRAP_EN adds resp_err and rejects requests with req_addr[1:0] != 0.
module data_memory_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        resp_err
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [1:0]       state;
  logic [3:0]       wait_cnt;
  logic             cap_write;
  logic [IDX_W-1:0] cap_idx;
  logic [31:0]      cap_wdata;
  logic             cap_misalign;
  logic [31:0]      resp_data_q;
  logic             err_q;
  logic [31:0]      mem [DEPTH_WORDS];

  logic             accept;
  logic [IDX_W-1:0] req_idx;
  logic             req_misalign;
  logic             enter_resp;
  logic             acc_write;
  logic [IDX_W-1:0] acc_idx;
  logic [31:0]      acc_wdata;
  logic             acc_misalign;

  assign accept  = req_valid && (state == ST_IDLE);
  assign req_idx = req_addr[2 +: IDX_W];

`ifdef MISALIGN_TRAP_EN
  assign req_misalign = |req_addr[1:0];
  assign resp_err     = err_q;
  wire unused_bits = ^{req_addr[31:2+IDX_W]};
`else
  assign req_misalign = 1'b0;
  wire unused_bits = ^{req_addr[31:2+IDX_W], req_addr[1:0], err_q};
`endif

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign resp_rdata = resp_data_q;

  // With zero wait states the access uses the live request; otherwise the captured one.
  always_comb begin
    acc_write    = cap_write;
    acc_idx      = cap_idx;
    acc_wdata    = cap_wdata;
    acc_misalign = cap_misalign;
    enter_resp   = 1'b0;
    if (state == ST_IDLE) begin
      acc_write    = req_write;
      acc_idx      = req_idx;
      acc_wdata    = req_wdata;
      acc_misalign = req_misalign;
      enter_resp   = accept && (WAIT_CYCLES == 0);
    end else if (state == ST_WAIT) begin
      enter_resp = (wait_cnt == 4'd0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      wait_cnt     <= 4'd0;
      cap_write    <= 1'b0;
      cap_idx      <= '0;
      cap_wdata    <= 32'd0;
      cap_misalign <= 1'b0;
      resp_data_q  <= 32'd0;
      err_q        <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= 32'd0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cap_write    <= req_write;
            cap_idx      <= req_idx;
            cap_wdata    <= req_wdata;
            cap_misalign <= req_misalign;
            wait_cnt     <= CNT_INIT;
            state        <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // The store commits on the edge entering RESP, so a following load sees it.
      if (enter_resp) begin
        err_q <= acc_misalign;
        if (acc_misalign) begin
          resp_data_q <= 32'd0;
        end else if (acc_write) begin
          mem[acc_idx] <= acc_wdata;
          resp_data_q  <= acc_wdata;
        end else begin
          resp_data_q <= mem[acc_idx];
        end
      end
    end
  end

endmodule
